// File: rtl/tap_pkg.sv
// Shared types and constants for the TAP cassette playback path.
package tap_pkg;

  localparam int CNT_W_DEF        = 24;
  localparam int TICK_MULT_SH_DEF = 3;
  localparam int V0_OVERFLOW_LEN  = 2048;

  localparam logic [1:0] TAP_V0 = 2'd0;
  localparam logic [1:0] TAP_V1 = 2'd1;
  localparam logic [1:0] TAP_V2 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_LEN,
    S_GET_EXT0,
    S_GET_EXT1,
    S_GET_EXT2,
    S_HOLD
  } fetchState_t;

endpackage

// File: rtl/tap_pulse_sequencer_if.sv
// Byte stream link between the 32-bit-to-byte slicer and the pulse sequencer.
interface tap_pulse_sequencer_if;

  logic       byte_valid;
  logic [7:0] byte_in;
  logic       byte_read;
  logic       slicer_restart;

  modport master (
    input  byte_valid,
    input  byte_in,
    output byte_read,
    output slicer_restart
  );

  modport slave (
    output byte_valid,
    output byte_in,
    input  byte_read,
    input  slicer_restart
  );

endinterface

// File: rtl/tap_pulse_sequencer_timer.sv
// Pulse-length down-counter producing the cass_read waveform; takes the next
// length from the fetch side on the same tick the current pulse ends.
module tap_pulse_timer
  import tap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restart,
  input  logic             i_tick,
  input  logic             i_halfwave,
  input  logic             i_loadValid,
  input  logic [CNT_W-1:0] i_loadLen,
  input  logic             i_moreData,
  output logic             o_take,
  output logic             o_cassRead,
  output logic             o_idle,
  output logic             o_underrun
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_halfLen;
  logic             r_active;
  logic             r_phase;
  logic             r_cassRead;
  logic             r_underrun;

  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_nextCount;
  logic             w_expire;

  assign w_len       = (i_loadLen == '0) ? CNT_W'(1) : i_loadLen;
  assign w_nextCount = r_count - CNT_W'(1);
  assign w_expire    = i_tick & r_active & (r_count == CNT_W'(1));
  assign o_take      = i_loadValid & i_tick & (~r_active | w_expire);

  assign o_cassRead = r_cassRead;
  assign o_idle     = ~r_active;
  assign o_underrun = r_underrun;

  // A freshly loaded length always starts low since L > L>>1 for any L >= 1;
  // in half-wave mode each load instead emits the next alternating level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_halfLen  <= '0;
      r_active   <= 1'b0;
      r_phase    <= 1'b0;
      r_cassRead <= 1'b1;
      r_underrun <= 1'b0;
    end else if (i_restart) begin
      r_count    <= '0;
      r_halfLen  <= '0;
      r_active   <= 1'b0;
      r_phase    <= 1'b0;
      r_cassRead <= 1'b1;
      r_underrun <= 1'b0;
    end else if (o_take) begin
      r_count   <= w_len;
      r_halfLen <= w_len >> 1;
      r_active  <= 1'b1;
      if (i_halfwave) begin
        r_cassRead <= r_phase;
        r_phase    <= ~r_phase;
      end else begin
        r_cassRead <= 1'b0;
      end
    end else if (w_expire) begin
      r_count    <= '0;
      r_active   <= 1'b0;
      r_cassRead <= 1'b1;
      if (i_moreData) r_underrun <= 1'b1;
    end else if (i_tick && r_active) begin
      r_count <= w_nextCount;
      if (!i_halfwave) r_cassRead <= ~(w_nextCount > r_halfLen);
    end
  end

endmodule

// File: rtl/tap_pulse_sequencer.sv
// TAP playback: fetches pulse lengths from the byte slicer and drives cass_read.
// Optional half-wave playback for version-2 files is built with TAP_HALFWAVE_EN.
module tap_pulse_sequencer
  import tap_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int TICK_MULT_SH = TICK_MULT_SH_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clk_en,
  input  logic        i_restart,
  input  logic        i_motor,
  input  logic        i_play,
  input  logic [1:0]  i_tap_version,
  input  logic [31:0] i_tap_length,
  tap_pulse_sequencer_if.master slicer,
  output logic        o_cass_read,
  output logic        o_done,
  output logic        o_underrun
);

  fetchState_t      r_state;
  logic [CNT_W-1:0] r_hold;
  logic [31:0]      r_bytesConsumed;
  logic             r_readLast;
  logic             r_done;

  logic             w_tick;
  logic             w_halfwave;
  logic             w_moreData;
  logic             w_inGet;
  logic             w_byteRead;
  logic             w_take;
  logic             w_timerIdle;
  logic [CNT_W-1:0] w_byteLen;

  assign w_tick     = i_clk_en & i_motor & i_play;
  assign w_moreData = r_bytesConsumed < i_tap_length;
  assign w_inGet    = (r_state == S_GET_LEN)  || (r_state == S_GET_EXT0) ||
                      (r_state == S_GET_EXT1) || (r_state == S_GET_EXT2);
  // The one-cycle gap after each read gives the slicer time to present the next byte.
  assign w_byteRead = w_inGet & slicer.byte_valid & ~r_readLast & w_moreData & ~i_restart;
  assign w_byteLen  = CNT_W'(slicer.byte_in) << TICK_MULT_SH;

`ifdef TAP_HALFWAVE_EN
  assign w_halfwave = (i_tap_version == TAP_V2);
`else
  assign w_halfwave = 1'b0;
`endif

  assign slicer.byte_read      = w_byteRead;
  assign slicer.slicer_restart = i_restart;
  assign o_done                = r_done;

  tap_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_restart   (i_restart),
    .i_tick      (w_tick),
    .i_halfwave  (w_halfwave),
    .i_loadValid (r_state == S_HOLD),
    .i_loadLen   (r_hold),
    .i_moreData  (w_moreData),
    .o_take      (w_take),
    .o_cassRead  (o_cass_read),
    .o_idle      (w_timerIdle),
    .o_underrun  (o_underrun)
  );

  // Running out of bytes part way through an extended length drops back to idle,
  // discarding the partial value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_hold          <= '0;
      r_bytesConsumed <= '0;
      r_readLast      <= 1'b0;
      r_done          <= 1'b0;
    end else if (i_restart) begin
      r_state         <= S_IDLE;
      r_hold          <= '0;
      r_bytesConsumed <= '0;
      r_readLast      <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_readLast <= w_byteRead;
      if (w_byteRead) r_bytesConsumed <= r_bytesConsumed + 32'd1;
      if (!w_moreData && w_timerIdle && r_state == S_IDLE) r_done <= 1'b1;
      case (r_state)
        S_IDLE: if (w_moreData) r_state <= S_GET_LEN;
        S_GET_LEN: begin
          if (!w_moreData) begin
            r_state <= S_IDLE;
          end else if (w_byteRead) begin
            if (slicer.byte_in != 8'd0) begin
              r_hold  <= w_byteLen;
              r_state <= S_HOLD;
            end else if (i_tap_version == TAP_V0) begin
              r_hold  <= CNT_W'(V0_OVERFLOW_LEN);
              r_state <= S_HOLD;
            end else begin
              r_hold  <= '0;
              r_state <= S_GET_EXT0;
            end
          end
        end
        S_GET_EXT0: begin
          if (!w_moreData) r_state <= S_IDLE;
          else if (w_byteRead) begin
            r_hold[7:0] <= slicer.byte_in;
            r_state     <= S_GET_EXT1;
          end
        end
        S_GET_EXT1: begin
          if (!w_moreData) r_state <= S_IDLE;
          else if (w_byteRead) begin
            r_hold[15:8] <= slicer.byte_in;
            r_state      <= S_GET_EXT2;
          end
        end
        S_GET_EXT2: begin
          if (!w_moreData) r_state <= S_IDLE;
          else if (w_byteRead) begin
            r_hold[23:16] <= slicer.byte_in;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: if (w_take) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_pulse_sequencer.sv
// Directed bench for tap_pulse_sequencer with a simple byte-slicer model.
module tb_tap_pulse_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clkEn;
  logic        restart;
  logic        motor;
  logic        play;
  logic [1:0]  tapVersion;
  logic [31:0] tapLength;
  logic        cassRead;
  logic        done;
  logic        underrun;

  tap_pulse_sequencer_if slicerIf ();

  tap_pulse_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clk_en      (clkEn),
    .i_restart     (restart),
    .i_motor       (motor),
    .i_play        (play),
    .i_tap_version (tapVersion),
    .i_tap_length  (tapLength),
    .slicer        (slicerIf),
    .o_cass_read   (cassRead),
    .o_done        (done),
    .o_underrun    (underrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8];
  int   memLen        = 0;
  int   availCount    = 0;
  int   ptr           = 0;
  int   rdCount       = 0;
  int   adjacentCount = 0;
  logic pendRead      = 1'b0;
  logic prevRead      = 1'b0;
  int   checks        = 0;
  int   failures      = 0;
  int   n;

  // Slicer model: a read seen before an edge commits on that edge, so the
  // pointer only moves on the falling edge after it.
  always @(negedge clk) begin
    if (pendRead) ptr = ptr + 1;
    pendRead = 1'b0;
    if (slicerIf.slicer_restart) begin
      ptr = 0;
    end else if (slicerIf.byte_read) begin
      pendRead = 1'b1;
      rdCount  = rdCount + 1;
      if (prevRead) adjacentCount = adjacentCount + 1;
    end
    prevRead = slicerIf.byte_read;
    slicerIf.byte_valid = (ptr < availCount) && (ptr < memLen);
    slicerIf.byte_in    = (ptr < 8) ? mem[ptr] : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ver, input int len, input int avail);
    tapVersion = ver;
    tapLength  = len;
    memLen     = len;
    availCount = avail;
  endtask

  task automatic doReset();
    reset_n  = 1'b0;
    restart  = 1'b0;
    tick();
    tick();
    ptr           = 0;
    rdCount       = 0;
    adjacentCount = 0;
    pendRead      = 1'b0;
    prevRead      = 1'b0;
    reset_n       = 1'b1;
  endtask

  task automatic waitLevel(input logic lvl, input int limit, input string tag);
    int k = 0;
    while (cassRead !== lvl && k < limit) begin
      tick();
      k++;
    end
    checkOutput(tag, cassRead, lvl);
  endtask

  // Counts samples at the given level; stops early once done rises.
  task automatic measureRun(input logic lvl, input int limit, output int cnt);
    cnt = 0;
    while (cassRead === lvl && done !== 1'b1 && cnt < limit) begin
      cnt++;
      tick();
    end
  endtask

  task automatic pulseRestart(input string tag);
    restart = 1'b1;
    #1;
    checkOutput({tag, "_slicer_restart_hi"}, slicerIf.slicer_restart, 1);
    tick();
    restart = 1'b0;
    #1;
    checkOutput({tag, "_slicer_restart_lo"}, slicerIf.slicer_restart, 0);
  endtask

  initial begin
    slicerIf.byte_valid = 1'b0;
    slicerIf.byte_in    = 8'h00;
    clkEn      = 1'b1;
    motor      = 1'b1;
    play       = 1'b1;
    restart    = 1'b0;
    tapVersion = 2'd1;
    tapLength  = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset values
    reset_n = 1'b0;
    tick();
    checkOutput("rst_cass_read", cassRead, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_byte_read", slicerIf.byte_read, 0);
    checkOutput("rst_slicer_restart", slicerIf.slicer_restart, 0);

    // Two back-to-back short pulses
    mem[0] = 8'h30;
    mem[1] = 8'h2F;
    applyStimulus(2'd1, 2, 2);
    doReset();
    waitLevel(1'b0, 20, "t1_start");
    measureRun(1'b0, 400, n); checkOutput("t1_low0", n, 192);
    measureRun(1'b1, 400, n); checkOutput("t1_high0", n, 192);
    measureRun(1'b0, 400, n); checkOutput("t1_low1", n, 188);
    measureRun(1'b1, 400, n); checkOutput("t1_high1_plus_done", n, 189);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_underrun", underrun, 0);
    checkOutput("t1_reads", rdCount, 2);

    // Version 1 extended length 0x002710
    mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'h27; mem[3] = 8'h00;
    applyStimulus(2'd1, 4, 4);
    doReset();
    waitLevel(1'b0, 40, "t2_start");
    measureRun(1'b0, 12000, n); checkOutput("t2_low", n, 5000);
    measureRun(1'b1, 12000, n); checkOutput("t2_high_plus_done", n, 5001);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_reads", rdCount, 4);
    checkOutput("t2_adjacent", adjacentCount, 0);

    // Version 0 overflow byte
    mem[0] = 8'h00;
    applyStimulus(2'd0, 1, 1);
    doReset();
    waitLevel(1'b0, 20, "t3_start");
    measureRun(1'b0, 3000, n); checkOutput("t3_low", n, 1024);
    measureRun(1'b1, 3000, n); checkOutput("t3_high_plus_done", n, 1025);

    // Motor drop in the middle of a 256-tick pulse
    mem[0] = 8'h20;
    applyStimulus(2'd1, 1, 1);
    doReset();
    waitLevel(1'b0, 20, "t4_start");
    n = 1;
    repeat (50) begin tick(); n++; end
    motor = 1'b0;
    repeat (100) begin tick(); n++; end
    checkOutput("t4_frozen_low", cassRead, 0);
    checkOutput("t4_frozen_done", done, 0);
    motor = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (done === 1'b1) break;
      n++;
    end
    checkOutput("t4_total_with_pause", n, 357);

    // Underrun: second byte withheld
    mem[0] = 8'h01; mem[1] = 8'h02;
    applyStimulus(2'd1, 2, 1);
    doReset();
    waitLevel(1'b0, 20, "t5_start");
    measureRun(1'b0, 100, n); checkOutput("t5_low", n, 4);
    repeat (3) tick();
    checkOutput("t5_no_underrun_yet", underrun, 0);
    tick();
    checkOutput("t5_underrun", underrun, 1);
    checkOutput("t5_cass_idle", cassRead, 1);
    repeat (490) tick();
    checkOutput("t5_still_idle", cassRead, 1);
    availCount = 2;
    waitLevel(1'b0, 20, "t5_resume");
    measureRun(1'b0, 100, n); checkOutput("t5_low2", n, 8);
    measureRun(1'b1, 100, n); checkOutput("t5_high2_plus_done", n, 9);
    checkOutput("t5_underrun_sticky", underrun, 1);
    checkOutput("t5_done", done, 1);

    // Restart clears sticky state, then restart again during the second extension byte
    availCount = 0;
    mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'h27; mem[3] = 8'h00;
    memLen    = 4;
    tapLength = 4;
    tick();
    pulseRestart("t6a");
    checkOutput("t6a_done", done, 0);
    checkOutput("t6a_underrun", underrun, 0);
    rdCount    = 0;
    availCount = 4;
    for (int k = 0; k < 50 && rdCount < 2; k++) tick();
    checkOutput("t6_reads_before_restart", rdCount, 2);
    pulseRestart("t6b");
    checkOutput("t6b_cass_read", cassRead, 1);
    checkOutput("t6b_done", done, 0);
    checkOutput("t6b_underrun", underrun, 0);
    rdCount = 0;
    waitLevel(1'b0, 40, "t6_start");
    measureRun(1'b0, 12000, n); checkOutput("t6_low", n, 5000);
    measureRun(1'b1, 12000, n); checkOutput("t6_high_plus_done", n, 5001);
    checkOutput("t6_reads_after_restart", rdCount, 4);

    // Version 2 file of three equal bytes
    mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'h10;
    applyStimulus(2'd2, 3, 3);
    doReset();
    waitLevel(1'b0, 20, "t7_start");
`ifdef TAP_HALFWAVE_EN
    measureRun(1'b0, 300, n); checkOutput("t7_hw_low0", n, 128);
    measureRun(1'b1, 300, n); checkOutput("t7_hw_high", n, 128);
    measureRun(1'b0, 300, n); checkOutput("t7_hw_low1", n, 128);
    tick();
    checkOutput("t7_hw_done", done, 1);
`else
    for (int p = 0; p < 2; p++) begin
      measureRun(1'b0, 300, n); checkOutput("t7_low", n, 64);
      measureRun(1'b1, 300, n); checkOutput("t7_high", n, 64);
    end
    measureRun(1'b0, 300, n); checkOutput("t7_low_last", n, 64);
    measureRun(1'b1, 300, n); checkOutput("t7_high_last_plus_done", n, 65);
`endif
    checkOutput("t7_cass_idle", cassRead, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/tap_pulse_sequencer.md
Name: tap_pulse_sequencer

Overview:
- Drives the cassette-playback datapath: pulls TAP-file bytes from the upstream 32-bit-to-byte slicer, decodes pulse lengths and generates the cass_read waveform to the CIA FLAG input.
- Owns the slicer's read/restart sequencing and the byte accounting against the file length.
- Keeps one decoded length prefetched so consecutive pulses have no gap.

Parameters:
- CNT_W, 24, pulse-length counter width in clk_en ticks.
- TICK_MULT_SH, 3, left shift applied to a non-zero TAP byte (×8 ticks).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_en  in  1  one-cycle C64 phi2 tick strobe.
- restart  in  1  synchronous rewind to file start.
- motor  in  1  cassette motor on (from CPU port).
- play  in  1  play key pressed.
- tap_version  in  2  TAP header version (0, 1, 2).
- tap_length  in  32  data byte count after header.
- byte_valid  in  1  slicer byte available.
- byte_in  in  8  slicer current byte.
- byte_read  out  1  one-cycle consume strobe to slicer.
- slicer_restart  out  1  one-cycle restart to slicer.
- cass_read  out  1  cassette read line, idle high.
- done  out  1  all bytes consumed and last pulse finished.
- underrun  out  1  sticky: pulse expired with no length ready.

Behaviour:
- Reset values: byte_read=0, slicer_restart=0, cass_read=1, done=0, underrun=0, counters 0, state S_IDLE, holding register empty.
- restart: same as reset, but synchronous. slicer_restart is asserted for exactly that cycle. restart has priority over every other event.
- Fetch FSM states: S_IDLE, S_GET_LEN, S_GET_EXT0, S_GET_EXT1, S_GET_EXT2, S_HOLD.
  - S_IDLE→S_GET_LEN when bytes_consumed<tap_length and the holding register is empty.
  - S_GET_LEN, byte_valid:
    - Pulse byte_read and increment bytes_consumed.
    - byte≠0: hold=byte<<TICK_MULT_SH, go to S_HOLD.
    - byte=0, version 0: hold=2048, go to S_HOLD.
    - byte=0, version≥1: go to S_GET_EXT0.
  - S_GET_EXT0..2: read 3 bytes little-endian into hold[23:0], each with byte_read and a count increment, then S_HOLD.
  - S_HOLD: wait until the timer takes the value, then S_IDLE.
- byte_read handshake:
  - Asserted only when byte_valid=1 in the same cycle.
  - Never asserted in two consecutive cycles; the one-cycle gap lets byte_in settle.
- Byte accounting: bytes_consumed is 32 bits and stops at tap_length. If bytes_consumed==tap_length mid-extended-length, the partial length is discarded and no further reads are issued.
- Pulse timer:
  - Runs only on clk_en & motor & play; otherwise the count freezes and cass_read holds its level.
  - On load of length L, the count becomes L. A loaded length of 0 is treated as 1.
  - cass_read=0 while count > L>>1, else 1. This gives a falling edge at pulse start, and the CIA counts falling edges.
  - When count==1 on an active tick, load the hold value the same cycle if present (zero-gap).
  - If no hold value is present, set underrun sticky, return cass_read to 1, and load on arrival.
- done=1 when bytes_consumed==tap_length, hold is empty and the timer is idle. Cleared only by restart or reset.
- tap_length change while running: undefined; software issues restart.
- Motor off mid-pulse: the pulse resumes exactly where it stopped.

Optional Feature:
- TAP_HALFWAVE_EN defined: tap_version=2 enables half-wave mode.
  - Each decoded length is one half-period.
  - cass_read toggles at each load instead of following the L>>1 rule.
  - The first half-wave after restart drives 0.
- Not defined: tap_version=2 behaves exactly as version 1.

Decomposition:
- Package tap_pkg:
  - Fetch-state enum.
  - TAP_V0/TAP_V1/TAP_V2 constants.
  - CNT_W default.
  - V0_OVERFLOW_LEN=2048.
- One sub-module tap_pulse_timer:
  - Count, waveform and half-wave toggle.
  - Load/ready handshake with the fetch FSM.
  - Fetch FSM and accounting stay in the top module.

Test Plan:
- v1, bytes 0x30,0x2F, tap_length=2, motor=play=1, clk_en every cycle:
  - cass_read low 192 ticks, high 192, low 188, high 188.
  - No idle tick between pulses; done=1 after the 760th tick.
- v1 bytes 00 10 27 00 → one pulse of 10000 ticks (5000 low), 4 byte_read strobes never adjacent. v0 byte 00 → 2048-tick pulse.
- byte_valid held low for 500 cycles after a 0x01 byte (8-tick pulse) → underrun=1 at tick 8, cass_read=1. Next byte 0x02 then yields a 16-tick pulse.
- Drop motor for 100 ticks mid-pulse of 0x20 → total pulse still 256 active ticks. cass_read frozen during the pause.
- restart asserted during S_GET_EXT1 → slicer_restart one cycle, cass_read=1, done=0, underrun=0, bytes_consumed=0. The next fetch begins from the first byte.
- With TAP_HALFWAVE_EN, v2, bytes 0x10,0x10,0x10 → cass_read 0/1/0 for 128 ticks each. Without the macro, same stimulus gives three 128-tick pulses at 64 low / 64 high.
